led_blinker_multi: RTL

//  Multi-channel LED blink/burst engine replacing the single fixed 50% blinker.
//  A shared prescaler turns the board clock into a slow tick.

---
 rtl/led_blinker_multi.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/led_blinker_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_blinker_multi : multi-channel LED blink/burst engine, shared tick      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module led_blinker_multi #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int TICK_HZ    = 1_000,
  parameter int CHANNELS   = 4,
  parameter int PERIOD_W   = 16,
  parameter int BURST_W    = 8,
  localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_high,
  input  logic [BURST_W-1:0]  cfg_bursts,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] burst_done
);

  localparam int DIV   = CLOCK_FREQ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEADY = 3'd1,
    S_RUN    = 3'd2,
    S_BURST  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  logic [PRE_W-1:0] prescale;
  logic             tick;
  logic             ready_q;
  logic             accept;

  assign tick      = (prescale == PRE_W'(DIV - 1));
  assign cfg_ready = ready_q;
  assign accept    = cfg_valid && ready_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prescale <= '0;
      ready_q  <= 1'b0;
    end else begin
      prescale <= tick ? '0 : prescale + PRE_W'(1);
      ready_q  <= 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    state_t              state, state_n;
    logic [PERIOD_W-1:0] period_q, high_q, phase, phase_n, last_phase;
    logic [BURST_W-1:0]  bursts_q, bcnt, bcnt_n;
    logic                led_q, led_n, done_q, done_n, sel, wrap;

    // Words aimed at a channel index beyond CHANNELS never match here and are dropped.
    assign sel        = accept && (cfg_chan == CHAN_W'(c));
    assign last_phase = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
    assign wrap       = tick && (phase == last_phase);

    always_comb begin
      state_n = state;
      phase_n = phase;
      bcnt_n  = bcnt;
      done_n  = 1'b0;
      led_n   = 1'b0;
      case (state)
        S_STEADY: led_n = 1'b1;
        S_RUN: begin
          led_n = (phase < high_q);
          if (tick) phase_n = wrap ? '0 : phase + PERIOD_W'(1);
        end
        S_BURST: begin
          // A zero burst count must never show high time, even for one cycle.
          led_n = (phase < high_q) && (bursts_q != '0);
          if (bcnt == bursts_q) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else if (tick) begin
            phase_n = wrap ? '0 : phase + PERIOD_W'(1);
            if (wrap) begin
              if (bcnt + BURST_W'(1) == bursts_q) begin
                state_n = S_DONE;
                done_n  = 1'b1;
              end else begin
                bcnt_n = bcnt + BURST_W'(1);
              end
            end
          end
        end
        default: led_n = 1'b0;
      endcase
      // A fresh config wins over any tick or burst completion in the same cycle.
      if (sel) begin
        phase_n = '0;
        bcnt_n  = '0;
        done_n  = 1'b0;
        case (cfg_mode)
          2'd1:    state_n = S_STEADY;
          2'd2:    state_n = S_RUN;
          2'd3:    state_n = S_BURST;
          default: state_n = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state    <= S_IDLE;
        phase    <= '0;
        bcnt     <= '0;
        led_q    <= 1'b0;
        done_q   <= 1'b0;
        period_q <= '0;
        high_q   <= '0;
        bursts_q <= '0;
      end else begin
        state  <= state_n;
        phase  <= phase_n;
        bcnt   <= bcnt_n;
        led_q  <= led_n;
        done_q <= done_n;
        if (sel) begin
          period_q <= cfg_period;
          high_q   <= cfg_high;
          bursts_q <= cfg_bursts;
        end
      end
    end

    assign led[c]        = led_q;
    assign burst_done[c] = done_q;
  end

endmodule
`default_nettype wire
